// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: MDU op codes, FSM states
// and the mapping from the decoder's EXE_*_OP codes onto MDU requests.
`ifndef EX_MULDIV_DEFINES
`define EX_MULDIV_DEFINES
`define MDU_MUL  3'd0
`define MDU_DIV  3'd1
`define MDU_MADD 3'd2
`define MDU_MSUB 3'd3
`endif

package ex_muldiv_pkg;

    localparam logic [2:0] MDU_MUL  = `MDU_MUL;
    localparam logic [2:0] MDU_DIV  = `MDU_DIV;
    localparam logic [2:0] MDU_MADD = `MDU_MADD;
    localparam logic [2:0] MDU_MSUB = `MDU_MSUB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_e;

    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [7:0] EXE_MADD_OP  = 8'b1010_0110;
    localparam logic [7:0] EXE_MADDU_OP = 8'b1010_1000;
    localparam logic [7:0] EXE_MSUB_OP  = 8'b1010_1010;
    localparam logic [7:0] EXE_MSUBU_OP = 8'b1010_1011;

    typedef struct packed {
        logic       valid;
        logic [2:0] op;
        logic       sgn;
    } mdu_req_t;

    // Decoder/EX glue: anything that is not an HI/LO arithmetic op yields valid=0.
    function automatic mdu_req_t exe_to_mdu(input logic [7:0] exe_op);
        mdu_req_t r;
        r = '{valid: 1'b1, op: MDU_MUL, sgn: 1'b0};
        case (exe_op)
            EXE_MULT_OP:  r = '{valid: 1'b1, op: MDU_MUL,  sgn: 1'b1};
            EXE_MULTU_OP: r = '{valid: 1'b1, op: MDU_MUL,  sgn: 1'b0};
            EXE_DIV_OP:   r = '{valid: 1'b1, op: MDU_DIV,  sgn: 1'b1};
            EXE_DIVU_OP:  r = '{valid: 1'b1, op: MDU_DIV,  sgn: 1'b0};
            EXE_MADD_OP:  r = '{valid: 1'b1, op: MDU_MADD, sgn: 1'b1};
            EXE_MADDU_OP: r = '{valid: 1'b1, op: MDU_MADD, sgn: 1'b0};
            EXE_MSUB_OP:  r = '{valid: 1'b1, op: MDU_MSUB, sgn: 1'b1};
            EXE_MSUBU_OP: r = '{valid: 1'b1, op: MDU_MSUB, sgn: 1'b0};
            default:      r = '{valid: 1'b0, op: MDU_MUL,  sgn: 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Request/result bundle between the EX stage (master) and the multiply/divide unit (slave).
interface ex_muldiv_if #(
    parameter int DATA_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic              sgn;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] hi_in;
    logic [DATA_W-1:0] lo_in;
    logic              cancel;
    logic              stall_req;
    logic              done;
    logic [DATA_W-1:0] hi_out;
    logic [DATA_W-1:0] lo_out;
    logic              hilo_wen;
    logic              div_zero;

    modport master (
        output start, op, sgn, opa, opb, hi_in, lo_in, cancel,
        input  stall_req, done, hi_out, lo_out, hilo_wen, div_zero
    );

    modport slave (
        input  start, op, sgn, opa, opb, hi_in, lo_in, cancel,
        output stall_req, done, hi_out, lo_out, hilo_wen, div_zero
    );
endinterface

// File: rtl/ex_muldiv_div_iter.sv
// Restoring divider datapath on unsigned magnitudes: one quotient bit per step.
// Exposes the post-step quotient/remainder so the final step can be registered directly.
module ex_muldiv_div_iter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              step_i,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              zero_o,
    output logic              last_o,
    output logic [DATA_W-1:0] quot_d_o,
    output logic [DATA_W-1:0] rem_d_o
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quot_q;
    logic [DATA_W-1:0] dvsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W:0]   trial_s;
    logic              ge_s;

    assign zero_o = (divisor_i == {DATA_W{1'b0}});
    assign last_o = (cnt_q == {CNT_W{1'b0}});

    // Trial subtraction; bit DATA_W of the difference set means the divisor did not fit.
    always_comb begin
        trial_s  = {rem_q, quot_q[DATA_W-1]} - {1'b0, dvsr_q};
        ge_s     = ~trial_s[DATA_W];
        quot_d_o = {quot_q[DATA_W-2:0], ge_s};
        rem_d_o  = ge_s ? trial_s[DATA_W-1:0] : {rem_q[DATA_W-2:0], quot_q[DATA_W-1]};
    end

    // Partial remainder, quotient shift register (holds the dividend bits still to consume) and step counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= {DATA_W{1'b0}};
            quot_q <= {DATA_W{1'b0}};
            dvsr_q <= {DATA_W{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else if (load_i) begin
            rem_q  <= {DATA_W{1'b0}};
            quot_q <= dividend_i;
            dvsr_q <= divisor_i;
            cnt_q  <= CNT_W'(DATA_W - 1);
        end else if (step_i) begin
            rem_q  <= rem_d_o;
            quot_q <= quot_d_o;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative HI/LO multiply/divide unit beside the EX-stage ALU: shift-add multiplier
// (MUL_BITS per cycle) with optional accumulate, restoring divider, sign fix-up on exit.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int MUL_BITS = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    ex_muldiv_if.slave mdu
);
    localparam int MUL_STEPS = DATA_W / MUL_BITS;
    localparam int CNT_W     = $clog2(DATA_W + 1);
    localparam int W2        = 2 * DATA_W;

    mdu_state_e state_q, state_d;

    logic [2:0]          op_q;
    logic                neg_q;
    logic                rneg_q;
    logic [DATA_W-1:0]   mcand_q;
    logic [W2-1:0]       acc_q;
    logic [W2-1:0]       base_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                done_q;
    logic                wen_q;
    logic                dz_q;

    logic [DATA_W-1:0]          opa_mag_s;
    logic [DATA_W-1:0]          opb_mag_s;
    logic                       accept_s;
    logic                       load_s;
    logic                       mul_step_s;
    logic                       div_step_s;
    logic                       mul_last_s;
    logic                       div_last_s;
    logic                       div_zero_s;
    logic                       stall_s;
    logic                       done_set_s;
    logic                       dz_set_s;
    logic [DATA_W+MUL_BITS-1:0] pp_s;
    logic [DATA_W+MUL_BITS-1:0] upper_s;
    logic [W2-1:0]              acc_step_s;
    logic [W2-1:0]              prod_s;
    logic [W2-1:0]              mul_res_s;
    logic [DATA_W-1:0]          quot_d_s;
    logic [DATA_W-1:0]          rem_d_s;
    logic [DATA_W-1:0]          res_hi_s;
    logic [DATA_W-1:0]          res_lo_s;

    // Magnitude of a possibly signed operand; the most-negative value maps to 2^(DATA_W-1).
    function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v, input logic s);
        return (s && v[DATA_W-1]) ? -v : v;
    endfunction

    assign opa_mag_s  = mag(mdu.opa, mdu.sgn);
    assign opb_mag_s  = mag(mdu.opb, mdu.sgn);
    assign accept_s   = (state_q == S_IDLE) && mdu.start && !mdu.cancel;
    assign mul_last_s = (cnt_q == {CNT_W{1'b0}});
    assign done_set_s = (state_d == S_DONE);
    assign dz_set_s   = (state_q == S_IDLE) && (state_d == S_DONE);

    ex_muldiv_div_iter #(
        .DATA_W(DATA_W)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (load_s),
        .step_i    (div_step_s),
        .dividend_i(opa_mag_s),
        .divisor_i (opb_mag_s),
        .zero_o    (div_zero_s),
        .last_o    (div_last_s),
        .quot_d_o  (quot_d_s),
        .rem_d_o   (rem_d_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; a zero divisor skips the iteration phase entirely.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!accept_s) begin
                    state_d = S_IDLE;
                end else if (mdu.op == MDU_DIV) begin
                    state_d = div_zero_s ? S_DONE : S_DIV;
                end else begin
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (mdu.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = mul_last_s ? S_DONE : S_MUL;
                end
            end
            S_DIV: begin
                if (mdu.cancel) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = div_last_s ? S_DONE : S_DIV;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: stall and datapath strobes.
    always_comb begin
        stall_s    = 1'b0;
        load_s     = 1'b0;
        mul_step_s = 1'b0;
        div_step_s = 1'b0;
        case (state_q)
            S_IDLE: begin
                stall_s = accept_s;
                load_s  = accept_s;
            end
            S_MUL: begin
                stall_s    = 1'b1;
                mul_step_s = !mdu.cancel;
            end
            S_DIV: begin
                stall_s    = 1'b1;
                div_step_s = !mdu.cancel;
            end
            S_DONE:  stall_s = 1'b0;
            default: stall_s = 1'b0;
        endcase
    end

    // Multiplier step (multiplier bits live in the low half of acc and shift out as product bits shift in) plus result fix-up.
    always_comb begin
        pp_s       = {{MUL_BITS{1'b0}}, mcand_q} * {{DATA_W{1'b0}}, acc_q[MUL_BITS-1:0]};
        upper_s    = {{MUL_BITS{1'b0}}, acc_q[W2-1:DATA_W]} + pp_s;
        acc_step_s = {upper_s, acc_q[DATA_W-1:MUL_BITS]};
        prod_s     = neg_q ? -acc_step_s : acc_step_s;
        case (op_q)
            MDU_MADD: mul_res_s = base_q + prod_s;
            MDU_MSUB: mul_res_s = base_q - prod_s;
            default:  mul_res_s = prod_s;
        endcase
        case (state_q)
            S_MUL: begin
                res_hi_s = mul_res_s[W2-1:DATA_W];
                res_lo_s = mul_res_s[DATA_W-1:0];
            end
            S_DIV: begin
                res_hi_s = rneg_q ? -rem_d_s : rem_d_s;
                res_lo_s = neg_q ? -quot_d_s : quot_d_s;
            end
            default: begin
                res_hi_s = {DATA_W{1'b0}};
                res_lo_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Operand capture, multiplier iteration and registered HI/LO results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= MDU_MUL;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            mcand_q <= {DATA_W{1'b0}};
            acc_q   <= {W2{1'b0}};
            base_q  <= {W2{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            hi_q    <= {DATA_W{1'b0}};
            lo_q    <= {DATA_W{1'b0}};
            done_q  <= 1'b0;
            wen_q   <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            if (load_s) begin
                op_q    <= mdu.op;
                neg_q   <= mdu.sgn & (mdu.opa[DATA_W-1] ^ mdu.opb[DATA_W-1]);
                rneg_q  <= mdu.sgn & mdu.opa[DATA_W-1];
                mcand_q <= opa_mag_s;
                acc_q   <= {{DATA_W{1'b0}}, opb_mag_s};
                base_q  <= {mdu.hi_in, mdu.lo_in};
                cnt_q   <= CNT_W'(MUL_STEPS - 1);
            end else if (mul_step_s) begin
                acc_q   <= acc_step_s;
                cnt_q   <= cnt_q - CNT_W'(1);
            end
            if (done_set_s) begin
                hi_q <= res_hi_s;
                lo_q <= res_lo_s;
            end
            done_q <= done_set_s;
            wen_q  <= done_set_s & ~dz_set_s;
            dz_q   <= dz_set_s;
        end
    end

    assign mdu.stall_req = stall_s;
    assign mdu.done      = done_q & ~mdu.cancel;
    assign mdu.hilo_wen  = wen_q & ~mdu.cancel;
    assign mdu.div_zero  = dz_q;
    assign mdu.hi_out    = hi_q;
    assign mdu.lo_out    = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: hand-computed HI/LO results, latency, stall, cancel and reset behaviour.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_fail;

    ex_muldiv_if #(.DATA_W(32)) mdu ();

    ex_muldiv #(
        .DATA_W  (32),
        .MUL_BITS(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .mdu  (mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        mdu.op    = op;
        mdu.sgn   = s;
        mdu.opa   = a;
        mdu.opb   = b;
        mdu.hi_in = h;
        mdu.lo_in = l;
        mdu.start = 1'b1;
        #1;
    endtask

    // Called right after issue(); busy_at raises start again (different operands) while the unit is busy.
    task automatic run_to_done(input string tag, input int exp_lat, input logic [31:0] exp_hi,
                               input logic [31:0] exp_lo, input logic exp_wen, input logic exp_dz,
                               input int busy_at);
        int lat;
        bit stall_ok;
        chk({tag, " stall_c"}, mdu.stall_req, 1);
        lat      = 0;
        stall_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            mdu.start = (k == busy_at);
            if (k == busy_at) begin
                mdu.opa = 32'd7;
                mdu.opb = 32'd1;
            end
            #1;
            if (mdu.done === 1'b1) begin
                lat = k;
                break;
            end
            if (mdu.stall_req !== 1'b1) stall_ok = 1'b0;
        end
        mdu.start = 1'b0;
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " stall_busy"}, stall_ok, 1);
        chk({tag, " hi"}, mdu.hi_out, exp_hi);
        chk({tag, " lo"}, mdu.lo_out, exp_lo);
        chk({tag, " hilo_wen"}, mdu.hilo_wen, exp_wen);
        chk({tag, " div_zero"}, mdu.div_zero, exp_dz);
        chk({tag, " stall_done"}, mdu.stall_req, 0);
        @(negedge clk);
        #1;
        chk({tag, " done_pulse"}, mdu.done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst_n = 1'b0;
        mdu.start = 1'b0; mdu.op = MDU_MUL; mdu.sgn = 1'b0; mdu.cancel = 1'b0;
        mdu.opa = 32'd0; mdu.opb = 32'd0; mdu.hi_in = 32'd0; mdu.lo_in = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst done", mdu.done, 0);
        chk("rst hilo_wen", mdu.hilo_wen, 0);
        chk("rst div_zero", mdu.div_zero, 0);
        chk("rst hi", mdu.hi_out, 0);
        chk("rst lo", mdu.lo_out, 0);
        chk("rst stall", mdu.stall_req, 0);

        issue(MDU_MUL, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0);
        run_to_done("multu_max", 17, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0, 0);

        issue(MDU_MUL, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0);
        run_to_done("mult_neg", 17, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b0, 0);

        issue(MDU_MADD, 1'b0, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
        run_to_done("madd_carry", 17, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 0);

        issue(MDU_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
        run_to_done("div_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1, 1'b0, 0);

        issue(MDU_DIV, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0);
        run_to_done("divu", 33, 32'd2, 32'd14, 1'b1, 1'b0, 0);

        issue(MDU_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
        run_to_done("div_minneg", 33, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b0, 0);

        issue(MDU_DIV, 1'b0, 32'd5, 32'd0, 32'd0, 32'd0);
        run_to_done("divu_zero", 1, 32'd0, 32'd0, 1'b0, 1'b1, 0);

        // Cancel arriving in DONE masks the result strobes in the same cycle.
        issue(MDU_DIV, 1'b0, 32'd9, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        mdu.start  = 1'b0;
        mdu.cancel = 1'b1;
        #1;
        chk("cancel_done done", mdu.done, 0);
        chk("cancel_done hilo_wen", mdu.hilo_wen, 0);
        @(negedge clk);
        mdu.cancel = 1'b0;
        #1;
        chk("cancel_done stall", mdu.stall_req, 0);

        // Cancel at divide iteration 10.
        issue(MDU_DIV, 1'b0, 32'd1000, 32'd3, 32'd0, 32'd0);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            mdu.start = 1'b0;
        end
        mdu.cancel = 1'b1;
        #1;
        chk("cancel_div stall", mdu.stall_req, 1);
        @(negedge clk);
        mdu.cancel = 1'b0;
        #1;
        chk("cancel_div done", mdu.done, 0);
        chk("cancel_div hilo_wen", mdu.hilo_wen, 0);
        chk("cancel_div idle_stall", mdu.stall_req, 0);

        // Restart right after the cancel; a start raised mid-operation must be ignored.
        issue(MDU_DIV, 1'b0, 32'd1000, 32'd3, 32'd0, 32'd0);
        run_to_done("div_restart", 33, 32'd1, 32'd333, 1'b1, 1'b0, 3);

        // Reset at multiply iteration 5.
        issue(MDU_MUL, 1'b0, 32'd6, 32'd7, 32'd0, 32'd0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            mdu.start = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_mid done", mdu.done, 0);
        chk("rst_mid hilo_wen", mdu.hilo_wen, 0);
        chk("rst_mid div_zero", mdu.div_zero, 0);
        chk("rst_mid hi", mdu.hi_out, 0);
        chk("rst_mid lo", mdu.lo_out, 0);
        chk("rst_mid stall", mdu.stall_req, 0);
        rst_n = 1'b1;

        issue(MDU_MSUB, 1'b1, 32'd3, 32'd4, 32'd0, 32'd10);
        run_to_done("msub", 17, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
